// File: rtl/mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    RETURN    = 2'd3
  } arb_state_t;

  // Requester ids double as bit positions in the per-requester vectors.
  localparam logic REQ_PTW  = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select: the requester named by ptr wins a tie.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Favoured requester first, otherwise whichever one is asking.
  always_comb begin
    grant = 2'b00;
    if (valid[ptr])       grant[ptr]  = 1'b1;
    else if (valid[~ptr]) grant[~ptr] = 1'b1;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the page-table walker and data port onto one memory port,
// one transaction in flight, with a response timeout. A timed-out request
// leaves a stale response owed by memory; it is swallowed before any new
// request is accepted so it can never be mistaken for a later reply.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [1:0][31:0] req_addr_i,
  output logic [1:0]       resp_valid_o,
  input  logic [1:0]       resp_ready_i,
  output logic [31:0]      resp_data_o,
  output logic             resp_err_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_resp_valid_i,
  output logic             mem_resp_ready_o,
  input  logic [31:0]      mem_data_i
);

  arb_state_t  state, state_n;
  logic        rr_ptr;
  logic        stale;
  logic [6:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        gid;
  logic [1:0]  grant;
  logic        req_fire;
  logic        timeout;

  rr_arbiter2 u_rr (
    .valid (req_valid_i),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // grant is only ever set on an asserted valid bit, so any grant in IDLE is a handshake.
  assign req_fire = (state == IDLE) && !stale && (|grant);
  assign timeout  = (wait_cnt == 7'(TIMEOUT_CYCLES - 1));

  // State register plus the per-transaction datapath latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= REQ_PTW;
      stale    <= 1'b0;
      wait_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      gid      <= REQ_PTW;
    end else begin
      state <= state_n;
      // The owed late response is dropped whenever it shows up.
      if (stale && mem_resp_valid_i) stale <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            addr_q <= req_addr_i[grant[1]];
            gid    <= grant[1];
          end
        end
        ISSUE: wait_cnt <= '0;
        WAIT_RESP: begin
          wait_cnt <= wait_cnt + 7'd1;
          // A real response in the timeout cycle takes priority.
          if (mem_resp_valid_i) begin
            data_q <= mem_data_i;
            err_q  <= 1'b0;
          end else if (timeout) begin
            data_q <= '0;
            err_q  <= 1'b1;
            stale  <= 1'b1;
          end
        end
        RETURN: if (resp_ready_i[gid]) rr_ptr <= ~gid;
        default: ;
      endcase
    end
  end

  // Next state and handshake outputs; everything forced low while in reset.
  always_comb begin
    state_n          = state;
    req_ready_o      = 2'b00;
    resp_valid_o     = 2'b00;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = stale;
    resp_data_o      = data_q;
    resp_err_o       = err_q;
    mem_addr_o       = addr_q;
    case (state)
      IDLE: begin
        if (!stale) begin
          req_ready_o = grant;
          if (req_fire) state_n = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_n = WAIT_RESP;
      end
      WAIT_RESP: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i || timeout) state_n = RETURN;
      end
      RETURN: begin
        resp_valid_o[gid] = 1'b1;
        if (resp_ready_i[gid]) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (rst) begin
      req_ready_o      = 2'b00;
      resp_valid_o     = 2'b00;
      mem_req_valid_o  = 1'b0;
      mem_resp_ready_o = 1'b0;
      resp_data_o      = '0;
      resp_err_o       = 1'b0;
      mem_addr_o       = '0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, SHALL set the number of WAIT_RESP cycles before a timeout error is returned.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid_i  input  2  per-requester request valid; bit 0 = page-table walker, bit 1 = data port.
REQ-005 req_ready_o  output  2  per-requester request ready.
REQ-006 req_addr_i  input  2x32  per-requester byte address.
REQ-007 resp_valid_o  output  2  per-requester response valid.
REQ-008 resp_ready_i  input  2  per-requester response ready.
REQ-009 resp_data_o  output  32  response data, shared by both requesters, meaningful only with resp_valid_o.
REQ-010 resp_err_o  output  1  response is a timeout error, qualified by resp_valid_o.
REQ-011 mem_req_valid_o  output  1  downstream memory request valid.
REQ-012 mem_req_ready_i  input  1  downstream memory request ready.
REQ-013 mem_addr_o  output  32  downstream byte address.
REQ-014 mem_resp_valid_i  input  1  downstream response valid.
REQ-015 mem_resp_ready_o  output  1  downstream response ready.
REQ-016 mem_data_i  input  32  downstream read data.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT_RESP and RETURN, with at most one transaction outstanding at a time.
REQ-018 In IDLE with stale_pending=0, the arbiter SHALL pick a winner among the asserted req_valid_i bits, favouring the requester indicated by rr_ptr, and SHALL drive req_ready_o combinationally to the winner only.
REQ-019 On a request handshake, the arbiter SHALL latch the address and grant id and move to ISSUE on the next edge.
REQ-020 In ISSUE, mem_req_valid_o SHALL be 1 and mem_addr_o SHALL carry the latched address.
REQ-021 In ISSUE, mem_req_valid_o and mem_addr_o SHALL hold stable until mem_req_ready_i is seen, after which the FSM SHALL move to WAIT_RESP.
REQ-022 In WAIT_RESP, mem_resp_ready_o SHALL be 1; on mem_resp_valid_i the arbiter SHALL latch mem_data_i, clear resp_err, and move to RETURN.
REQ-023 In WAIT_RESP, a 7-bit wait counter SHALL start at 0 and increment each cycle.
REQ-024 If the wait counter reaches TIMEOUT_CYCLES-1 with no mem_resp_valid_i, the arbiter SHALL latch data 0, set resp_err, set stale_pending and move to RETURN.
REQ-025 If mem_resp_valid_i arrives in the same cycle as the timeout, the real response SHALL win and no timeout SHALL be flagged.
REQ-026 In RETURN, resp_valid_o SHALL be asserted only on the granted requester's bit, with resp_data_o and resp_err_o held stable.
REQ-027 In RETURN, on resp_ready_i of the granted requester the arbiter SHALL set rr_ptr to the other requester and move to IDLE.
REQ-028 While stale_pending=1, mem_resp_ready_o SHALL be 1, req_ready_o SHALL be 0, the next mem_resp_valid_i SHALL be discarded, and stale_pending SHALL then clear.
REQ-029 A requester that deasserts req_valid_i before its handshake SHALL NOT be granted; only one bit of req_ready_o and of resp_valid_o SHALL ever be high.
REQ-030 With a single-cycle-ready memory, latency from request handshake to resp_valid_o SHALL be 1 (ISSUE) + memory response latency + 1 cycle.

Reset
REQ-031 While rst is high, the FSM SHALL go to IDLE, rr_ptr to 0, stale_pending to 0, the wait counter to 0, and the latched data and address to 0.
REQ-032 While rst is high, all outputs SHALL be 0, including req_ready_o, resp_valid_o, mem_req_valid_o and mem_resp_ready_o.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction with no response delivered; the downstream memory SHALL be reset on the same rst.

Structure
REQ-034 A shared package mem_pkg SHALL hold the state enum arb_state_t, the requester id constants REQ_PTW=0 and REQ_DATA=1, and the default timeout constant.
REQ-035 Winner selection SHALL live in one sub-module, rr_arbiter2: a combinational 2-way round-robin with inputs valid[1:0] and ptr, and output grant one-hot.

Verification
REQ-036 Scenario: PTW reads 0x190 alone -> resp_valid_o[0] with data 0x2000_0001, resp_err_o=0.
REQ-037 Scenario: both requesters valid in the same IDLE cycle (PTW 0x190, data 0x320), rr_ptr=0 -> PTW served first, then data returns 0x3000_0001; ports alternate over 4 back-to-back pairs.
REQ-038 Scenario: memory holds mem_req_ready_i low for 5 cycles -> mem_req_valid_o and mem_addr_o are stable throughout.
REQ-039 Scenario: requester holds resp_ready_i low for 10 cycles -> resp_valid_o and resp_data_o are held; no new grant occurs.
REQ-040 Scenario: memory stub withholds the response for 70 cycles with TIMEOUT_CYCLES=64 -> error response with data 0 after 64 cycles; the late response is discarded; the next request returns correct data.
REQ-041 Scenario: rst asserted in WAIT_RESP -> all outputs 0 on the next cycle; after release the first request completes normally.
